// File: rtl/cpu_pkg.sv
// Shared datapath constants for the multicycle MIPS core: register indices,
// data/address widths and the stack-pointer reset value.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam logic [31:0] SP_RESET_VALUE = 32'd227;

endpackage : cpu_pkg

// File: rtl/reg_bank_read_port.sv
// One combinational read port of the register file: index select, $zero force
// and, when REG_BANK_WRITE_BYPASS_EN is defined, write-through forwarding.
module reg_bank_read_port
  import cpu_pkg::REG_ZERO;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int NREGS  = 2 ** ADDR_W
) (
  input  logic [NREGS-1:0][DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]            rd_idx_i,
`ifdef REG_BANK_WRITE_BYPASS_EN
  input  logic                         wr_en_i,
  input  logic [ADDR_W-1:0]            wr_idx_i,
  input  logic [DATA_W-1:0]            wr_data_i,
`endif
  output logic [DATA_W-1:0]            rd_data_o
);

  // NOTE: the unconditional first assignment keeps this block purely
  // combinational; without it some paths would leave rd_data_o unassigned
  // and synthesis would infer a latch.
  always_comb begin
    rd_data_o = regs_i[rd_idx_i];
`ifdef REG_BANK_WRITE_BYPASS_EN
    if (wr_en_i && (wr_idx_i != ADDR_W'(REG_ZERO)) && (wr_idx_i == rd_idx_i)) begin
      rd_data_o = wr_data_i;
    end
`endif
    // $zero wins over both storage and forwarding.
    if (rd_idx_i == ADDR_W'(REG_ZERO)) begin
      rd_data_o = '0;
    end
  end

endmodule : reg_bank_read_port

// File: rtl/reg_bank.sv
// 32 x 32 register file with two async read ports and one write port; $zero is
// hardwired and $sp resets to SP_RESET. Optional forwarding: REG_BANK_WRITE_BYPASS_EN.
module reg_bank
  import cpu_pkg::REG_ZERO;
#(
  parameter int               DATA_W   = cpu_pkg::DATA_W,
  parameter int               ADDR_W   = cpu_pkg::ADDR_W,
  parameter int               SP_INDEX = int'(cpu_pkg::REG_SP),
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(cpu_pkg::SP_RESET_VALUE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0][DATA_W-1:0] regs_d;
  logic                         wr_en;

  assign wr_en = reg_write && (write_reg != ADDR_W'(REG_ZERO));

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[write_reg] = write_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value, independent of block evaluation order.
  // NOTE: the storage is a flop array rather than a RAM macro because every
  // entry needs an architectural reset value ($sp in particular).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q           <= '0;
      regs_q[SP_INDEX] <= SP_RESET;
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REG_BANK_WRITE_BYPASS_EN
  // Forwarding is masked during reset so the ports show the reset contents.
  logic byp_en;
  assign byp_en = reg_write && reset_n;
`endif

  reg_bank_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_port1 (
    .regs_i    (regs_q),
    .rd_idx_i  (read_reg1),
`ifdef REG_BANK_WRITE_BYPASS_EN
    .wr_en_i   (byp_en),
    .wr_idx_i  (write_reg),
    .wr_data_i (write_data),
`endif
    .rd_data_o (read_data1)
  );

  reg_bank_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_port2 (
    .regs_i    (regs_q),
    .rd_idx_i  (read_reg2),
`ifdef REG_BANK_WRITE_BYPASS_EN
    .wr_en_i   (byp_en),
    .wr_idx_i  (write_reg),
    .wr_data_i (write_data),
`endif
    .rd_data_o (read_data2)
  );

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank; expectations follow the build's
// REG_BANK_WRITE_BYPASS_EN setting.
module tb_reg_bank;

  logic        clk;
  logic        reset_n;
  logic        reg_write;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef REG_BANK_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_bank dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .reg_write  (reg_write),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = idx;
    write_data = data;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
  endtask

  task automatic read_pair(input logic [4:0] r1, input logic [4:0] r2);
    read_reg1 = r1;
    read_reg2 = r2;
    #1;
  endtask

  initial begin
    reset_n    = 1'b1;
    reg_write  = 1'b0;
    read_reg1  = '0;
    read_reg2  = '0;
    write_reg  = '0;
    write_data = '0;

    // 1: reset asserted between edges is visible immediately.
    #12;
    read_reg1 = 5'd29;
    read_reg2 = 5'd5;
    reset_n   = 1'b0;
    #1;
    check("rst_sp_async", read_data1, 32'd227);
    check("rst_r5_async", read_data2, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_sp_held", read_data1, 32'd227);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 2: basic write, neighbour unaffected.
    do_write(5'd8, 32'hDEADBEEF);
    read_pair(5'd8, 5'd9);
    check("wr8_r1", read_data1, 32'hDEADBEEF);
    check("wr8_r9", read_data2, 32'd0);

    // 3: writes to $zero are discarded and never forwarded.
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd0;
    write_data = 32'h12345678;
    read_pair(5'd0, 5'd0);
    check("zero_pre_p1", read_data1, 32'd0);
    check("zero_pre_p2", read_data2, 32'd0);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    check("zero_post_p1", read_data1, 32'd0);
    check("zero_post_p2", read_data2, 32'd0);

    // 4: read-during-write returns old value unless forwarding is built in.
    do_write(5'd10, 32'h11);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd10;
    write_data = 32'h22;
    read_pair(5'd10, 5'd10);
    check("rdw_pre_p1", read_data1, BYPASS ? 32'h22 : 32'h11);
    check("rdw_pre_p2", read_data2, BYPASS ? 32'h22 : 32'h11);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    check("rdw_post_p1", read_data1, 32'h22);
    check("rdw_post_p2", read_data2, 32'h22);

    // 5: reset dominates a write landing on the same edge.
    do_write(5'd31, 32'hCAFE);
    read_pair(5'd31, 5'd29);
    check("ra_cafe", read_data1, 32'hCAFE);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd31;
    write_data = 32'hBEEF;
    @(posedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_ra_clr", read_data1, 32'd0);
    check("rst_sp_set", read_data2, 32'd227);
    @(negedge clk);
    reg_write = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);

    // 6: walk every index, then idle cycles with junk on the write bus.
    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'(i * 3));
    end
    @(negedge clk);
    reg_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      write_reg  = 5'(k + 4);
      write_data = 32'hFFFF_0000 | 32'(k);
      @(negedge clk);
    end
    for (int i = 1; i < 32; i++) begin
      read_pair(5'(i), 5'(32 - i));
      check($sformatf("walk_p1_r%0d", i), read_data1, 32'(i * 3));
      check($sformatf("walk_p2_r%0d", 32 - i), read_data2, 32'((32 - i) * 3));
    end
    read_pair(5'd0, 5'd29);
    check("walk_zero", read_data1, 32'd0);
    check("walk_sp", read_data2, 32'd87);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_reg_bank
